// File: rtl/mux2_rr_arbiter.sv
// Purpose : round-robin merge of two valid/ready requesters onto one registered 2:1 mux output.
// Latency : a word accepted on edge N is presented on m_out after edge N (one cycle).
// Backpress: m_out_ready=0 with a full output stage holds everything and drops both readies.
//
// Ports:
//   clk, rst                   - single clock, synchronous active-high reset
//   a_valid/a_data/a_ready     - requester A handshake
//   b_valid/b_data/b_ready     - requester B handshake
//   sel                        - combinational mux select (1 = A, 0 = B)
//   m_out_valid/m_out/m_out_ready/m_out_src - registered output stream and its source tag
//   cnt_a, cnt_b               - saturating per-source grant counters (debug)
module mux2_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             sel,
    output logic             m_out_valid,
    output logic [WIDTH-1:0] m_out,
    input  logic             m_out_ready,
    output logic             m_out_src,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef enum logic {
        PTR_B = 1'b0,
        PTR_A = 1'b1
    } ptr_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    ptr_t             ptr_q,   ptr_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             src_q,   src_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    logic load_en;
    logic grant_a;
    logic grant_b;
    logic grant_any;
    logic [WIDTH-1:0] mux_dat;

    // The stage can take a new word when empty or when its current word leaves this cycle.
    assign load_en = (state_q == ST_EMPTY) || m_out_ready;

    // A lone requester always wins; on contention the pointer decides.
    // Grants are independent of load_en so sel keeps tracking arbitration during a stall.
    assign grant_a   = a_valid && (!b_valid || (ptr_q == PTR_A));
    assign grant_b   = b_valid && (!a_valid || (ptr_q == PTR_B));
    assign grant_any = grant_a || grant_b;

    assign sel     = grant_a;
    assign mux_dat = sel ? a_data : b_data;

    assign a_ready = load_en && grant_a;
    assign b_ready = load_en && grant_b;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        src_d   = src_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;

        if (load_en) begin
            if (grant_any) begin
                state_d = ST_FULL;
                data_d  = mux_dat;
                src_d   = sel;
                // Hand priority to the other side even if it is idle right now.
                ptr_d   = grant_a ? PTR_B : PTR_A;
                if (grant_a && (cnt_a_q != CNT_MAX)) begin
                    cnt_a_d = cnt_a_q + CNT_W'(1);
                end
                if (grant_b && (cnt_b_q != CNT_MAX)) begin
                    cnt_b_d = cnt_b_q + CNT_W'(1);
                end
            end else begin
                // Drain (or stay empty); the last word and its tag stay visible.
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= PTR_A;
            data_q  <= '0;
            src_q   <= 1'b0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            src_q   <= src_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign m_out_valid = (state_q == ST_FULL);
    assign m_out       = data_q;
    assign m_out_src   = src_q;
    assign cnt_a       = cnt_a_q;
    assign cnt_b       = cnt_b_q;

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 32-bit 2:1 mux datapath between requester A and requester B.
- Each requester uses a valid/ready handshake. The block generates the mux select, registers the selected word into a one-entry output stage, and presents it downstream under valid/ready.
- Sits in front of any consumer that needs a single stream merged from two sources. Exposes the select and per-source grant counters for debug.

Parameters:
- WIDTH, 32, data width of both requesters and of the output.
- CNT_W, 16, width of each saturating grant counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A has a word.
- a_data  input  WIDTH  requester A word.
- a_ready  output  1  A's word is accepted this cycle.
- b_valid  input  1  requester B has a word.
- b_data  input  WIDTH  requester B word.
- b_ready  output  1  B's word is accepted this cycle.
- sel  output  1  combinational mux select; 1 selects A, 0 selects B.
- m_out_valid  output  1  output register holds a word.
- m_out  output  WIDTH  registered output word.
- m_out_ready  input  1  downstream accepts m_out this cycle.
- m_out_src  output  1  source of the word in m_out; 1 = A, 0 = B.
- cnt_a  output  CNT_W  number of words granted to A, saturating.
- cnt_b  output  CNT_W  number of words granted to B, saturating.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - m_out_valid=0, m_out=0, m_out_src=0, cnt_a=0, cnt_b=0.
  - Priority pointer = A.
  - Reset takes precedence over any handshake in the same cycle.
  - A word held in the output register at reset is discarded.
- Output stage states:
  - EMPTY (m_out_valid=0).
  - FULL (m_out_valid=1).
  - load_en = !m_out_valid || m_out_ready.
- Arbitration (combinational each cycle):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the side named by the priority pointer.
  - Neither valid: no grant; sel=0.
  - sel = 1 when A is granted, 0 otherwise.
- Ready outputs:
  - a_ready = load_en && grant A.
  - b_ready = load_en && grant B.
  - At most one ready is high in any cycle.
  - Ready never depends on the requester's own data.
- Transfer on an accepting edge (load_en && a grant):
  - m_out <= selected data.
  - m_out_src <= sel.
  - m_out_valid <= 1.
  - The priority pointer moves to the non-granted side, even if the other side was idle.
  - The granted side's counter increments and saturates at 2^CNT_W-1 (no wrap).
- Drain only (load_en, no grant, m_out_ready=1): m_out_valid <= 0; m_out and m_out_src hold their last values.
- Stall (m_out_valid=1, m_out_ready=0):
  - m_out, m_out_src, pointer and counters all hold.
  - a_ready=b_ready=0.
  - sel still reflects the current arbitration.
- Simultaneous drain and load in one cycle: m_out_valid stays 1 and the new word replaces the old. Sustained throughput is 1 word/cycle.
- Latency: accepted on edge N, visible on m_out after edge N (one cycle).
- Fairness: with both requesters continuously valid and m_out_ready=1, grants alternate A,B,A,B,... starting from A after reset.
- Requesters must hold valid and data stable until their ready is seen. The block does not check this.

Test Plan:
- Reset, then a_valid=1, a_data=32'hAAAA_AAAA, b_valid=0, m_out_ready=1 -> a_ready=1 and sel=1 in that cycle; next cycle m_out=32'hAAAA_AAAA, m_out_valid=1, m_out_src=1, cnt_a=1.
- Both valid (A=32'hAAAA_AAAA, B=32'hBBBB_BBBB), m_out_ready=1, 6 cycles -> m_out sequence A,B,A,B,A,B; cnt_a=3, cnt_b=3; sel toggles every cycle.
- Both valid, m_out_ready=0 for 4 cycles after first load -> m_out holds 32'hAAAA_AAAA; a_ready=b_ready=0; counters frozen; on release, B is granted next.
- Only B valid for 3 cycles, m_out_ready=1 -> B granted each cycle with sel=0, cnt_b=3; then both valid -> A granted first, because the pointer points to A after each B grant.
- rst=1 asserted while m_out_valid=1 and both valid -> next cycle m_out_valid=0, m_out=0, cnt_a=cnt_b=0; first grant after reset is A.
- CNT_W=2, only A valid for 5 transfers -> cnt_a stops at 3 and does not wrap.
